// File: rtl/aucohl_fifo_th_pkg.sv
// Shared types and helpers for the thresholded synchronous FIFO.
package aucohl_fifo_th_pkg;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  function automatic int fifo_depth(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/aucohl_fifo_th_mem.sv
// FIFO storage: DW x 2**AW register array, one write port, one async read port.
module aucohl_fifo_th_mem
  import aucohl_fifo_th_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  localparam int DEPTH = fifo_depth(AW);

  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/aucohl_fifo_th.sv
// Synchronous show-ahead FIFO with level count, almost-full/empty thresholds,
// sticky overflow/underflow flags and synchronous flush.
module aucohl_fifo_th
  import aucohl_fifo_th_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          clr_flags,
  input  logic          wr,
  input  logic [DW-1:0] wdata,
  input  logic          rd,
  output logic [DW-1:0] rdata,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   level,
  input  logic [AW:0]   afull_th,
  input  logic [AW:0]   aempty_th,
  output logic          afull,
  output logic          aempty,
  output logic          overflow,
  output logic          underflow
);

  localparam int          DEPTH   = fifo_depth(AW);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_level;
  logic          r_overflow;
  logic          r_underflow;

  logic          w_wr_ok;
  logic          w_rd_ok;
  logic          w_we;
  fifo_op_e      w_op;

  assign empty  = (r_level == '0);
  assign full   = (r_level == DEPTH_L);
  assign afull  = (r_level >= afull_th);
  assign aempty = (r_level <= aempty_th);
  assign level  = r_level;

  assign overflow  = r_overflow;
  assign underflow = r_underflow;

  // A write into a full FIFO is fine when a read frees the head slot this cycle.
  assign w_wr_ok = wr & (~full | rd);
  assign w_rd_ok = rd & ~empty;
  assign w_op    = fifo_op_e'({w_wr_ok, w_rd_ok});
  assign w_we    = w_wr_ok & ~flush & ~rst;

  aucohl_fifo_th_mem #(
    .DW (DW),
    .AW (AW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wptr),
    .i_wdata (wdata),
    .i_raddr (r_rptr),
    .o_rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_level     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_wr_ok) r_wptr <= r_wptr + 1'b1;
      if (w_rd_ok) r_rptr <= r_rptr + 1'b1;
      case (w_op)
        OP_PUSH: r_level <= r_level + 1'b1;
        OP_POP:  r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      // A fresh violation in the clearing cycle keeps the flag set.
      r_overflow  <= (r_overflow  & ~clr_flags) | (wr & full & ~rd);
      r_underflow <= (r_underflow & ~clr_flags) | (rd & empty);
    end
  end

endmodule
